// File: rtl/multi_format_counter_pkg.sv
// Shared constants and helpers for the multi-format modulo counter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the default 24 h / 12 h clock-format limits, the format-count ceiling
// and the range clamp used by both the load path and the format-switch path.
package multi_format_counter_pkg;

    // Largest number of runtime formats a counter instance may carry.
    localparam int MAX_FORMATS = 4;

    // Default clock-format limits (5-bit digits): 24 h counts 0..23, 12 h counts 1..12.
    localparam int          CLK_W    = 5;
    localparam logic [4:0]  WRAP_24H = 5'd0;
    localparam logic [4:0]  TERM_24H = 5'd23;
    localparam logic [4:0]  WRAP_12H = 5'd1;
    localparam logic [4:0]  TERM_12H = 5'd12;

    // Clamp val into [lo, hi]. Operates on a 32-bit carrier so one function
    // serves any counter width; callers zero-extend in and truncate out.
    function automatic logic [31:0] clamp(input logic [31:0] val,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
        logic [31:0] res;
        res = val;
        if (val > hi) begin
            res = hi;
        end else if (val < lo) begin
            res = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/multi_format_counter_format_limit_lut.sv
// Unpacks the per-format wrap/terminal limits for one format index.
// Latency: purely combinational.
// Backpressure: none (no handshake).
//
// Ports:
//   idx_i  - format index to look up
//   wrap_o - wrap (lowest) value of that format
//   term_o - terminal (highest) value of that format
// An index outside 0..NUM_FORMATS-1 returns format 0's limits; the top level
// never acts on an out-of-range index, so this only keeps the mux fully defined.
module format_limit_lut
    import multi_format_counter_pkg::*;
#(
    parameter int                           WIDTH       = CLK_W,
    parameter int                           NUM_FORMATS = 2,
    parameter int                           SEL_W       = 1,
    parameter logic [NUM_FORMATS*WIDTH-1:0] WRAP_VALUES = {WRAP_12H, WRAP_24H},
    parameter logic [NUM_FORMATS*WIDTH-1:0] TERM_VALUES = {TERM_12H, TERM_24H}
) (
    input  logic [SEL_W-1:0] idx_i,
    output logic [WIDTH-1:0] wrap_o,
    output logic [WIDTH-1:0] term_o
);

    always_comb begin
        wrap_o = WRAP_VALUES[WIDTH-1:0];
        term_o = TERM_VALUES[WIDTH-1:0];
        for (int i = 1; i < NUM_FORMATS; i++) begin
            if (idx_i == SEL_W'(i)) begin
                wrap_o = WRAP_VALUES[i*WIDTH +: WIDTH];
                term_o = TERM_VALUES[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/multi_format_counter.sv
// Modulo up/down counter with runtime-selectable wrap/terminal formats and cascade flag.
// Latency: counter/format_changed one clock after sampling; flag/format_err combinational.
// Backpressure: none; enable is a per-cycle step request, flag drives the next stage's enable.
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   enable, up_down     - step request and direction (1 = up)
//   format_sel          - requested format; switches when valid and different
//   load, load_value    - synchronous load, clamped into the active format
//   counter             - registered count
//   flag                - carry/borrow, high in the cycle whose edge wraps
//   format_changed      - one-cycle pulse after a switch edge
//   format_err          - format_sel is not a defined format
module multi_format_counter
    import multi_format_counter_pkg::*;
#(
    parameter int                           WIDTH       = CLK_W,
    parameter int                           NUM_FORMATS = 2,
    parameter int                           SEL_W       = 1,
    parameter logic [NUM_FORMATS*WIDTH-1:0] WRAP_VALUES = {WRAP_12H, WRAP_24H},
    parameter logic [NUM_FORMATS*WIDTH-1:0] TERM_VALUES = {TERM_12H, TERM_24H}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic [SEL_W-1:0] format_sel,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] counter,
    output logic             flag,
    output logic             format_changed,
    output logic             format_err
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks. TERM < 2**WIDTH holds by construction
    // of the packed vectors, so only WRAP <= TERM needs checking per format.
    // ------------------------------------------------------------------
    if (NUM_FORMATS < 1 || NUM_FORMATS > MAX_FORMATS) begin : g_bad_num_formats
        $fatal(1, "multi_format_counter: NUM_FORMATS must be 1..%0d", MAX_FORMATS);
    end
    if ((1 << SEL_W) < NUM_FORMATS) begin : g_bad_sel_w
        $fatal(1, "multi_format_counter: SEL_W too narrow for NUM_FORMATS");
    end
    for (genvar g = 0; g < NUM_FORMATS; g++) begin : g_fmt_check
        if (WRAP_VALUES[g*WIDTH +: WIDTH] > TERM_VALUES[g*WIDTH +: WIDTH]) begin : g_bad_limits
            $fatal(1, "multi_format_counter: format %0d has WRAP > TERM", g);
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] count_q, count_d;
    logic [SEL_W-1:0] fmt_q,   fmt_d;
    logic             chg_q,   chg_d;

    // Limits of the active format and of the requested format.
    logic [WIDTH-1:0] w_cur, t_cur;
    logic [WIDTH-1:0] w_new, t_new;

    format_limit_lut #(
        .WIDTH       (WIDTH),
        .NUM_FORMATS (NUM_FORMATS),
        .SEL_W       (SEL_W),
        .WRAP_VALUES (WRAP_VALUES),
        .TERM_VALUES (TERM_VALUES)
    ) u_lut_cur (
        .idx_i  (fmt_q),
        .wrap_o (w_cur),
        .term_o (t_cur)
    );

    format_limit_lut #(
        .WIDTH       (WIDTH),
        .NUM_FORMATS (NUM_FORMATS),
        .SEL_W       (SEL_W),
        .WRAP_VALUES (WRAP_VALUES),
        .TERM_VALUES (TERM_VALUES)
    ) u_lut_new (
        .idx_i  (format_sel),
        .wrap_o (w_new),
        .term_o (t_new)
    );

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic sel_valid;
    logic switch_pending;
    logic at_wrap;
    logic at_term;
    logic keep_on_switch;
    logic [WIDTH-1:0] load_clamped;

    assign sel_valid      = (32'(format_sel) < 32'(NUM_FORMATS));
    assign switch_pending = (format_sel != fmt_q) & sel_valid;
    assign at_wrap        = (count_q == w_cur);
    assign at_term        = (count_q == t_cur);

    // A count already inside the new format's range survives the switch.
    assign keep_on_switch = (clamp(32'(count_q), 32'(w_new), 32'(t_new)) == 32'(count_q));
    assign load_clamped   = WIDTH'(clamp(32'(load_value), 32'(w_cur), 32'(t_cur)));

    // flag must mirror exactly the condition that makes the next edge wrap,
    // so every higher-priority action that suppresses counting also masks it.
    assign flag       = enable & ~reset & ~switch_pending & ~load &
                        (up_down ? at_term : at_wrap);
    assign format_err = ~sel_valid;

    // ------------------------------------------------------------------
    // Next state: switch > load > enable (reset handled in the register)
    // ------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        fmt_d   = fmt_q;
        chg_d   = 1'b0;
        if (switch_pending) begin
            fmt_d   = format_sel;
            count_d = keep_on_switch ? count_q : w_new;
            chg_d   = 1'b1;
        end else if (load) begin
            count_d = load_clamped;
        end else if (enable) begin
            if (up_down) begin
                count_d = at_term ? w_cur : count_q + WIDTH'(1);
            end else begin
                count_d = at_wrap ? t_cur : count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= WRAP_VALUES[WIDTH-1:0];
            fmt_q   <= '0;
            chg_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            fmt_q   <= fmt_d;
            chg_q   <= chg_d;
        end
    end

    assign counter        = count_q;
    assign format_changed = chg_q;

endmodule

// File: tb/tb_multi_format_counter.sv
module tb_multi_format_counter;

    logic       clk = 1'b0;
    logic       rst, en, ud, ld;
    logic [4:0] lv;
    logic       sel0;
    logic [1:0] sel1;

    logic [4:0] cnt0, cnt1;
    logic       flag0, flag1, chg0, chg1, err0, err1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Default two-format clock counter (24 h / 12 h).
    multi_format_counter dut0 (
        .clk            (clk),
        .reset          (rst),
        .enable         (en),
        .up_down        (ud),
        .format_sel     (sel0),
        .load           (ld),
        .load_value     (lv),
        .counter        (cnt0),
        .flag           (flag0),
        .format_changed (chg0),
        .format_err     (err0)
    );

    // Three formats: 24 h, 12 h, degenerate 5..5; format_sel = 3 is invalid.
    multi_format_counter #(
        .WIDTH       (5),
        .NUM_FORMATS (3),
        .SEL_W       (2),
        .WRAP_VALUES ({5'd5, 5'd1, 5'd0}),
        .TERM_VALUES ({5'd5, 5'd12, 5'd23})
    ) dut1 (
        .clk            (clk),
        .reset          (rst),
        .enable         (en),
        .up_down        (ud),
        .format_sel     (sel1),
        .load           (ld),
        .load_value     (lv),
        .counter        (cnt1),
        .flag           (flag1),
        .format_changed (chg1),
        .format_err     (err1)
    );

    // Reference model: format tables and abstract state per instance.
    int nf [2]    = '{2, 3};
    int wv [2][4] = '{'{0, 1, 0, 0}, '{0, 1, 5, 0}};
    int tv [2][4] = '{'{23, 12, 0, 0}, '{23, 12, 5, 0}};
    int m_cnt [2] = '{0, 0};
    int m_fmt [2] = '{0, 0};
    int m_chg [2] = '{0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of stimulus on both instances, checked against the model.
    task automatic step(input bit r, input bit e, input bit u, input bit l,
                        input int v, input int s0, input int s1);
        int  s, w, t;
        bit  valid, ef;
        bit  sw [2];
        rst = r; en = e; ud = u; ld = l;
        lv = v[4:0]; sel0 = s0[0]; sel1 = s1[1:0];
        #1;
        for (int k = 0; k < 2; k++) begin
            s     = (k == 0) ? s0 : s1;
            valid = (s < nf[k]);
            sw[k] = valid && (s != m_fmt[k]);
            w     = wv[k][m_fmt[k]];
            t     = tv[k][m_fmt[k]];
            ef    = e && !r && !sw[k] && !l && (u ? (m_cnt[k] == t) : (m_cnt[k] == w));
            chk($sformatf("flag%0d", k), (k == 0) ? flag0 : flag1, ef);
            chk($sformatf("format_err%0d", k), (k == 0) ? err0 : err1, !valid);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            s = (k == 0) ? s0 : s1;
            w = wv[k][m_fmt[k]];
            t = tv[k][m_fmt[k]];
            m_chg[k] = 0;
            if (r) begin
                m_cnt[k] = wv[k][0];
                m_fmt[k] = 0;
            end else if (sw[k]) begin
                m_fmt[k] = s;
                if (m_cnt[k] < wv[k][s] || m_cnt[k] > tv[k][s]) m_cnt[k] = wv[k][s];
                m_chg[k] = 1;
            end else if (l) begin
                m_cnt[k] = (v > t) ? t : (v < w) ? w : v;
            end else if (e) begin
                if (u) m_cnt[k] = (m_cnt[k] == t) ? w : m_cnt[k] + 1;
                else   m_cnt[k] = (m_cnt[k] == w) ? t : m_cnt[k] - 1;
            end
            chk($sformatf("counter%0d", k), (k == 0) ? cnt0 : cnt1, m_cnt[k]);
            chk($sformatf("format_changed%0d", k), (k == 0) ? chg0 : chg1, m_chg[k]);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; ud = 1'b1; ld = 1'b0; lv = '0; sel0 = 1'b0; sel1 = 2'd0;
        @(posedge clk);
        #1;

        // Reset
        step(1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0);
        chk("reset_counter0", cnt0, 0);
        chk("reset_counter1", cnt1, 0);

        // 24 h count-up across the wrap
        for (int i = 0; i < 25; i++) begin
            step(0, 1, 1, 0, 0, 0, 0);
            chk("up_seq", cnt0, (i + 1) % 24);
        end

        // Switch to 12 h (count 1 in range), then count down through the wrap
        step(0, 1, 1, 0, 0, 1, 0);
        chk("switch_keep1", cnt0, 1);
        step(0, 1, 0, 0, 0, 1, 0);
        chk("down_wrap", cnt0, 12);
        step(0, 1, 0, 0, 0, 1, 0);
        chk("down_dec", cnt0, 11);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);
        chk("hold", cnt0, 11);

        // Switch clamping and back-to-back switches
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 17, 0, 0);
        step(0, 1, 1, 0, 0, 1, 0);
        chk("switch_17", cnt0, 1);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("b2b_pulse", chg0, 1);
        step(0, 0, 1, 1, 7, 0, 0);
        step(0, 0, 1, 0, 0, 1, 0);
        chk("switch_7", cnt0, 7);

        // Load clamping, load beats enable
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 30, 0, 0);
        chk("load_clamp_hi", cnt0, 23);
        step(0, 0, 1, 0, 0, 1, 0);
        step(0, 0, 1, 1, 5, 1, 0);
        step(0, 0, 1, 1, 0, 1, 0);
        chk("load_clamp_lo", cnt0, 1);

        // Invalid selector on the 3-format instance, then degenerate format
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 1, 3);
        chk("invalid_fmt_hold", dut1.fmt_q, 0);
        step(0, 1, 1, 0, 0, 1, 2);
        chk("degen_switch", cnt1, 5);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 1, 2);
        chk("degen_hold", cnt1, 5);

        // Reset overrides load, enable and a pending switch at count 9
        step(0, 0, 1, 0, 0, 0, 2);
        step(0, 0, 1, 1, 9, 0, 2);
        chk("pre_reset9", cnt0, 9);
        step(1, 1, 1, 1, 20, 1, 1);
        chk("reset_over_cnt", cnt0, 0);
        chk("reset_over_chg", chg0, 0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1),
                 ($urandom_range(0, 5) == 0),
                 $urandom_range(0, 31),
                 (($urandom_range(0, 7) == 0) ? $urandom_range(0, 1) : int'(sel0)),
                 (($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : int'(sel1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
